mips_uart_mmio: RTL and testbench

Parametrised memory-mapped UART for the MIPS150 CPU. It bridges the CPU load/store path to the FPGA_SERIAL_RX/FPGA_SERIAL_TX pins and provides TX and RX FIFOs of configurable depth. Baud rate is configurable, and the block keeps sticky error flags and an RX-ready interrupt line. It sits beside the data memory in the top level and is selected by the address decoder.

---
 rtl/mips_uart_mmio.sv | 237 +++++++++++++++++++++++
 tb/tb_mips_uart_mmio.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_uart_mmio.sv
// Memory-mapped UART for the MIPS150 CPU.
// TX/RX FIFOs, sticky error flags and an RX-ready interrupt.
module mips_uart_mmio #(
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  addr,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic        serial_in,
  output logic        serial_out,
  output logic        rx_irq
);
  localparam int BIT_TIME = CLOCK_FREQ / BAUD_RATE;
  localparam int TW = $clog2(BIT_TIME + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [TW-1:0] T_END = TW'(BIT_TIME - 1);
  localparam logic [TW-1:0] T_MID = TW'(BIT_TIME / 2 - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} ser_t;

  logic [1:0] sel;
  logic sel_st, sel_rx, sel_er;
  logic tx_req, tx_push, tx_pop, tx_full, tx_empty;
  logic rx_push, rx_pop, rx_full, rx_empty;
  logic [7:0] tx_head, rx_head;
  logic [2:0] err;
  logic set_ovr, set_frm, err_wr;
  logic unused_bits;

  assign sel    = addr[3:2];
  assign sel_st = sel == 2'd0;
  assign sel_rx = sel == 2'd1;
  assign sel_er = sel == 2'd3;
  assign err_wr = wr_en && sel_er;
  assign tx_req = wr_en && sel == 2'd2;
  assign tx_push = tx_req && (!tx_full || tx_pop);
  assign rx_pop = rd_en && sel_rx && !rx_empty;
  assign unused_bits = ^{addr[1:0], wdata[31:8]};

  // TX FIFO
  logic [7:0] tx_mem [FIFO_DEPTH];
  logic [AW-1:0] tx_wp, tx_rp;
  logic [CW-1:0] tx_cnt;
  assign tx_empty = tx_cnt == '0;
  assign tx_full  = tx_cnt == CW'(FIFO_DEPTH);
  assign tx_head  = tx_mem[tx_rp];

  always_ff @(posedge clk) begin
    if (!rst) begin
      tx_wp  <= '0;
      tx_rp  <= '0;
      tx_cnt <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + AW'(1);
      if (tx_pop) tx_rp <= tx_rp + AW'(1);
      tx_cnt <= tx_cnt + CW'(tx_push) - CW'(tx_pop);
    end
  end

  always_ff @(posedge clk)
    if (tx_push) tx_mem[tx_wp] <= wdata[7:0];

  // RX FIFO
  logic [7:0] rx_mem [FIFO_DEPTH];
  logic [AW-1:0] rx_wp, rx_rp;
  logic [CW-1:0] rx_cnt, rx_cnt_n;
  logic [7:0] rx_sh, rx_sh_n;
  assign rx_empty = rx_cnt == '0;
  assign rx_full  = rx_cnt == CW'(FIFO_DEPTH);
  assign rx_head  = rx_mem[rx_rp];
  assign rx_cnt_n = rx_cnt + CW'(rx_push) - CW'(rx_pop);

  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_wp  <= '0;
      rx_rp  <= '0;
      rx_cnt <= '0;
      rx_irq <= 1'b0;
    end else begin
      if (rx_push) rx_wp <= rx_wp + AW'(1);
      if (rx_pop) rx_rp <= rx_rp + AW'(1);
      rx_cnt <= rx_cnt_n;
      rx_irq <= rx_cnt_n != '0;
    end
  end

  always_ff @(posedge clk)
    if (rx_push) rx_mem[rx_wp] <= rx_sh;

  // TX FSM
  ser_t tx_st, tx_nst;
  logic [TW-1:0] tx_tmr, tx_tmr_n;
  logic [2:0] tx_bit, tx_bit_n;
  logic [7:0] tx_sh, tx_sh_n;
  logic tx_out_n;

  always_ff @(posedge clk) begin
    if (!rst) begin
      tx_st      <= IDLE;
      tx_tmr     <= '0;
      tx_bit     <= '0;
      tx_sh      <= '0;
      serial_out <= 1'b1;
    end else begin
      tx_st      <= tx_nst;
      tx_tmr     <= tx_tmr_n;
      tx_bit     <= tx_bit_n;
      tx_sh      <= tx_sh_n;
      serial_out <= tx_out_n;
    end
  end

  always_comb begin
    tx_nst   = tx_st;
    tx_tmr_n = tx_tmr + TW'(1);
    tx_bit_n = tx_bit;
    tx_sh_n  = tx_sh;
    tx_pop   = 1'b0;
    unique case (tx_st)
      IDLE: begin
        tx_tmr_n = '0;
        if (!tx_empty) begin
          tx_pop   = 1'b1;
          tx_sh_n  = tx_head;
          tx_bit_n = '0;
          tx_nst   = START;
        end
      end
      START: if (tx_tmr == T_END) begin
        tx_tmr_n = '0;
        tx_nst   = DATA;
      end
      DATA: if (tx_tmr == T_END) begin
        tx_tmr_n = '0;
        tx_sh_n  = {1'b0, tx_sh[7:1]};
        tx_bit_n = tx_bit + 3'd1;
        if (tx_bit == 3'd7) tx_nst = STOP;
      end
      STOP: if (tx_tmr == T_END) begin
        tx_tmr_n = '0;
        tx_nst   = IDLE;
      end
      default: tx_nst = IDLE;
    endcase
    // Pin is registered off the next state so it never glitches.
    tx_out_n = 1'b1;
    if (tx_nst == START) tx_out_n = 1'b0;
    if (tx_nst == DATA) tx_out_n = tx_sh_n[0];
  end

  // RX synchroniser and FSM
  logic rx_s1, rx_s2, rx_prev;
  ser_t rx_st, rx_nst;
  logic [TW-1:0] rx_tmr, rx_tmr_n;
  logic [2:0] rx_bit, rx_bit_n;

  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
      rx_st   <= IDLE;
      rx_tmr  <= '0;
      rx_bit  <= '0;
      rx_sh   <= '0;
    end else begin
      rx_s1   <= serial_in;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
      rx_st   <= rx_nst;
      rx_tmr  <= rx_tmr_n;
      rx_bit  <= rx_bit_n;
      rx_sh   <= rx_sh_n;
    end
  end

  always_comb begin
    rx_nst   = rx_st;
    rx_tmr_n = rx_tmr + TW'(1);
    rx_bit_n = rx_bit;
    rx_sh_n  = rx_sh;
    rx_push  = 1'b0;
    set_ovr  = 1'b0;
    set_frm  = 1'b0;
    unique case (rx_st)
      IDLE: begin
        rx_tmr_n = '0;
        if (rx_prev && !rx_s2) rx_nst = START;
      end
      START: if (rx_tmr == T_MID) begin
        rx_tmr_n = '0;
        rx_bit_n = '0;
        rx_nst   = rx_s2 ? IDLE : DATA;
      end
      DATA: if (rx_tmr == T_END) begin
        rx_tmr_n = '0;
        rx_sh_n  = {rx_s2, rx_sh[7:1]};
        rx_bit_n = rx_bit + 3'd1;
        if (rx_bit == 3'd7) rx_nst = STOP;
      end
      STOP: if (rx_tmr == T_END) begin
        rx_tmr_n = '0;
        rx_nst   = IDLE;
        if (!rx_s2) set_frm = 1'b1;
        else if (rx_full && !rx_pop) set_ovr = 1'b1;
        else rx_push = 1'b1;
      end
      default: rx_nst = IDLE;
    endcase
  end

  // Sticky flags: a set event wins over a same-cycle clear.
  always_ff @(posedge clk) begin
    if (!rst) err <= '0;
    else err <= (err & ~({3{err_wr}} & wdata[2:0]))
              | {tx_req && !tx_push, set_frm, set_ovr};
  end

  always_ff @(posedge clk) begin
    if (!rst) rdata <= '0;
    else if (rd_en) begin
      unique case (1'b1)
        sel_st: rdata <= {29'b0, tx_st != IDLE, !rx_empty, !tx_full};
        sel_rx: rdata <= {24'b0, rx_empty ? 8'h00 : rx_head};
        sel_er: rdata <= {29'b0, err};
        default: rdata <= '0;
      endcase
    end
  end
endmodule

// File: tb/tb_mips_uart_mmio.sv
// Bench for mips_uart_mmio: register table, framing sequences
// and randomized traffic against a queue-based model.
module tb_mips_uart_mmio;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [3:0] addr = '0;
  logic wr_en = 1'b0;
  logic rd_en = 1'b0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic serial_in = 1'b1;
  logic serial_out;
  logic rx_irq;
  int checks = 0;
  int passed = 0;

  mips_uart_mmio #(
    .CLOCK_FREQ(10_000_000),
    .BAUD_RATE(1_000_000),
    .FIFO_DEPTH(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .addr(addr),
    .wr_en(wr_en),
    .rd_en(rd_en),
    .wdata(wdata),
    .rdata(rdata),
    .serial_in(serial_in),
    .serial_out(serial_out),
    .rx_irq(rx_irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  a;
    bit          wr;
    bit          rd;
    logic [31:0] wd;
    logic [31:0] exp;
    bit          chk;
  } vec_t;

  task automatic check(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, got, exp);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_wr(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    addr = a;
    wdata = d;
    wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic bus_rd(input logic [3:0] a, output logic [31:0] d);
    @(negedge clk);
    addr = a;
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    d = rdata;
  endtask

  task automatic slot(input logic v);
    serial_in = v;
    repeat (10) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    slot(1'b0);
    for (int i = 0; i < 8; i++) slot(b[i]);
    slot(stop);
    serial_in = 1'b1;
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b0;
    repeat (n) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic wait_tx_start(output bit ok);
    int w;
    w = 0;
    while (serial_out !== 1'b0 && w < 8) begin
      @(negedge clk);
      w++;
    end
    ok = (serial_out === 1'b0);
  endtask

  task automatic tx_decode(output logic [7:0] b, output logic stop,
                           output bit ok);
    wait_tx_start(ok);
    repeat (5) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      repeat (10) @(negedge clk);
      b[i] = serial_out;
    end
    repeat (10) @(negedge clk);
    stop = serial_out;
    repeat (6) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t vecs[11];
    logic [31:0] d;
    logic [31:0] exp;
    logic [7:0] b;
    logic [7:0] pat;
    logic [7:0] got_b;
    logic st;
    logic e;
    bit ok;
    int m;
    int op;
    logic [7:0] rxq[$];
    logic [2:0] flags;
    logic [2:0] errm;

    vecs[0]  = '{4'h0, 1'b0, 1'b1, 32'h0,  32'h1, 1'b1};
    vecs[1]  = '{4'h0, 1'b0, 1'b0, 32'h0,  32'h1, 1'b1};
    vecs[2]  = '{4'h4, 1'b0, 1'b1, 32'h0,  32'h0, 1'b1};
    vecs[3]  = '{4'h8, 1'b0, 1'b1, 32'h0,  32'h0, 1'b1};
    vecs[4]  = '{4'hC, 1'b0, 1'b1, 32'h0,  32'h0, 1'b1};
    vecs[5]  = '{4'h3, 1'b0, 1'b1, 32'h0,  32'h1, 1'b1};
    vecs[6]  = '{4'h7, 1'b0, 1'b1, 32'h0,  32'h0, 1'b1};
    vecs[7]  = '{4'h0, 1'b1, 1'b0, 32'hFF, 32'h0, 1'b0};
    vecs[8]  = '{4'h0, 1'b0, 1'b1, 32'h0,  32'h1, 1'b1};
    vecs[9]  = '{4'h4, 1'b1, 1'b1, 32'hFF, 32'h0, 1'b1};
    vecs[10] = '{4'h0, 1'b0, 1'b0, 32'h0,  32'h0, 1'b1};

    do_reset(3);
    check("rst_serial_out", {31'b0, serial_out}, 32'h1);
    check("rst_rdata", rdata, 32'h0);
    check("rst_rx_irq", {31'b0, rx_irq}, 32'h0);

    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      addr  = vecs[i].a;
      wr_en = vecs[i].wr;
      rd_en = vecs[i].rd;
      wdata = vecs[i].wd;
      @(negedge clk);
      wr_en = 1'b0;
      rd_en = 1'b0;
      if (vecs[i].chk) check($sformatf("vec%0d", i), rdata, vecs[i].exp);
    end

    pat = 8'hA5;
    bus_wr(4'h8, 32'hA5);
    wait_tx_start(ok);
    check("tx_start_seen", {31'b0, ok}, 32'h1);
    for (int s = 0; s < 10; s++) begin
      if (s == 0) e = 1'b0;
      else if (s == 9) e = 1'b1;
      else e = pat[s-1];
      m = 0;
      repeat (10) begin
        if (serial_out === e) m++;
        @(negedge clk);
      end
      check($sformatf("tx_slot%0d", s), m, 10);
    end
    bus_wr(4'h8, 32'h5A);
    cycles(20);
    bus_rd(4'h0, d);
    check("status_busy", d, 32'h5);
    cycles(100);
    bus_rd(4'h0, d);
    check("status_idle", d, 32'h1);

    pat = 8'h3C;
    slot(1'b0);
    for (int i = 0; i < 8; i++) slot(pat[i]);
    check("rx_irq_pre", {31'b0, rx_irq}, 32'h0);
    slot(1'b1);
    check("rx_irq_post", {31'b0, rx_irq}, 32'h1);
    cycles(3);
    bus_rd(4'h4, d);
    check("rx_data", d, 32'h3C);
    bus_rd(4'h0, d);
    check("rx_status_after", d, 32'h1);
    check("rx_irq_clr", {31'b0, rx_irq}, 32'h0);

    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1);
    cycles(3);
    bus_rd(4'hC, d);
    check("err_overrun", d, 32'h1);
    for (int i = 1; i <= 5; i++) begin
      bus_rd(4'h4, d);
      check($sformatf("rx_fifo%0d", i), d, (i <= 4) ? 32'(i) : 32'h0);
    end
    bus_wr(4'hC, 32'h1);
    bus_rd(4'hC, d);
    check("err_clr", d, 32'h0);

    send_frame(8'h55, 1'b0);
    cycles(3);
    bus_rd(4'hC, d);
    check("err_frame", d, 32'h2);
    bus_rd(4'h0, d);
    check("frame_nopush", d, 32'h1);
    bus_wr(4'hC, 32'h2);
    serial_in = 1'b0;
    cycles(3);
    serial_in = 1'b1;
    cycles(120);
    bus_rd(4'hC, d);
    check("glitch_noerr", d, 32'h0);
    bus_rd(4'h0, d);
    check("glitch_nopush", d, 32'h1);

    for (int i = 0; i < 6; i++) bus_wr(4'h8, 32'h10 + 32'(i));
    bus_rd(4'hC, d);
    check("err_txdrop", d, 32'h4);
    bus_rd(4'h0, d);
    check("status_txfull", d, 32'h4);

    do_reset(2);
    bus_rd(4'hC, d);
    check("rst_err_clear", d, 32'h0);
    send_frame(8'h77, 1'b1);
    cycles(3);
    check("pre_rx_irq", {31'b0, rx_irq}, 32'h1);
    bus_wr(4'h8, 32'hA5);
    wait_tx_start(ok);
    check("tx6_start", {31'b0, ok}, 32'h1);
    cycles(41);
    bus_wr(4'h8, 32'h11);
    cycles(2);
    check("bit3_low", {31'b0, serial_out}, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_sout", {31'b0, serial_out}, 32'h1);
    check("rst_mid_irq", {31'b0, rx_irq}, 32'h0);
    rst = 1'b1;
    bus_rd(4'h0, d);
    check("rst_mid_status", d, 32'h1);
    bus_rd(4'h4, d);
    check("rst_mid_rxempty", d, 32'h0);
    m = 0;
    repeat (120) begin
      if (serial_out === 1'b1) m++;
      @(negedge clk);
    end
    check("rst_mid_quiet", m, 120);

    do_reset(2);
    rxq.delete();
    flags = '0;
    for (int it = 0; it < 40; it++) begin
      op = $urandom_range(0, 4);
      b = 8'($urandom);
      case (op)
        0: begin
          st = ($urandom_range(0, 3) != 0);
          send_frame(b, st);
          cycles(2);
          if (!st) flags[1] = 1'b1;
          else if (rxq.size() == 4) flags[0] = 1'b1;
          else rxq.push_back(b);
        end
        1: begin
          bus_rd(4'h4, d);
          exp = (rxq.size() != 0) ? {24'h0, rxq.pop_front()} : 32'h0;
          check("rnd_rxdata", d, exp);
        end
        2: begin
          bus_rd(4'hC, d);
          check("rnd_err", d, {29'h0, flags});
          errm = 3'($urandom);
          bus_wr(4'hC, {29'h0, errm});
          flags = flags & ~errm;
        end
        3: begin
          bus_rd(4'h0, d);
          exp = {29'h0, 1'b0, rxq.size() != 0, 1'b1};
          check("rnd_status", d, exp);
        end
        default: begin
          bus_wr(4'h8, {24'h0, b});
          tx_decode(got_b, st, ok);
          check("rnd_tx_start", {31'b0, ok}, 32'h1);
          check("rnd_tx_byte", {24'h0, got_b}, {24'h0, b});
          check("rnd_tx_stop", {31'b0, st}, 32'h1);
        end
      endcase
      check("rnd_irq", {31'b0, rx_irq}, {31'b0, rxq.size() != 0});
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
